wb_rng_fifo: RTL and testbench

WB_RNG_FIFO -- requirements
Module: wb_rng_fifo

---
 rtl/wb_rng_fifo_if.sv | 27 ++
 rtl/wb_rng_fifo.sv | 151 +++++++++++++++
 tb/tb_wb_rng_fifo.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_rng_fifo_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wb_rng_fifo_if                                               |
// | Description : Wishbone classic slave bus bundle for the RNG FIFO block.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface wb_rng_fifo_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface
`default_nettype wire

// File: rtl/wb_rng_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wb_rng_fifo                                                  |
// | Description : Round-robin bank of xorshift32 generators feeding an output  |
// |               FIFO, read and controlled over a Wishbone slave port.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module wb_rng_fifo #(
  parameter int          CHANNELS   = 2,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] SEED       = 32'h0000_0001,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
  input  wire logic   wb_clk_i,
  input  wire logic   wb_rst_i,
  wb_rng_fifo_if.slave wbs
);

  localparam int          AW     = $clog2(FIFO_DEPTH);
  localparam int          RRW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [31:0] GOLDEN = 32'h9E37_79B9;

  function automatic logic [31:0] xs_step(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  // Per-channel seed decorrelation so channels never share a sequence.
  function automatic logic [31:0] seed_mix(input logic [31:0] v, input int i);
    return v ^ (32'(i) * GOLDEN);
  endfunction

  logic                ack_q;
  logic [31:0]         dat_q;
  logic                en_q;
  logic                underflow_q;
  logic [31:0]         s_q [CHANNELS];
  logic [RRW-1:0]      rr_q, rr_d;
  logic [31:0]         mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wptr_q, rptr_q;
  logic [AW:0]         count_q, count_d;

  logic                w_req, w_wr_ctrl, w_wr_seed, w_rd_data;
  logic [1:0]          w_reg;
  logic                w_empty, w_full, w_pop, w_push;
  logic [31:0]         w_next, w_seed_v, w_seed_eff, w_status, w_rdata;

  assign w_req     = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~ack_q &
                     (wbs.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign w_reg     = wbs.wbs_adr_i[3:2];
  assign w_wr_ctrl = w_req &  wbs.wbs_we_i & (w_reg == 2'd0);
  assign w_wr_seed = w_req &  wbs.wbs_we_i & (w_reg == 2'd2);
  assign w_rd_data = w_req & ~wbs.wbs_we_i & (w_reg == 2'd3);

  assign w_empty = (count_q == '0);
  assign w_full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign w_pop   = w_rd_data & ~w_empty;
  // A seed reload flushes the FIFO, so it must suppress any push in the same cycle.
  assign w_push  = en_q & (~w_full | w_pop) & ~w_wr_seed;
  assign w_next  = xs_step(s_q[rr_q]);

  // SEED is write-only, so unselected byte lanes contribute zero.
  assign w_seed_v   = wbs.wbs_dat_i & {{8{wbs.wbs_sel_i[3]}}, {8{wbs.wbs_sel_i[2]}},
                                       {8{wbs.wbs_sel_i[1]}}, {8{wbs.wbs_sel_i[0]}}};
  assign w_seed_eff = (w_seed_v == 32'h0) ? SEED : w_seed_v;
  assign w_status   = {16'b0, 8'(count_q), 5'b0, underflow_q, w_full, w_empty};

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;

  // Read mux and next-state for round-robin index and FIFO occupancy.
  always_comb begin
    w_rdata = 32'h0;
    case (w_reg)
      2'd0:    w_rdata = {31'b0, en_q};
      2'd1:    w_rdata = w_status;
      2'd2:    w_rdata = 32'h0;
      default: w_rdata = w_empty ? 32'h0 : mem_q[rptr_q];
    endcase
    rr_d = (rr_q == RRW'(CHANNELS - 1)) ? '0 : rr_q + 1'b1;
    count_d = count_q;
    if (w_push && !w_pop)      count_d = count_q + 1'b1;
    else if (!w_push && w_pop) count_d = count_q - 1'b1;
  end

  // Bus response: one-cycle ack, read data only alongside ack.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      dat_q <= 32'h0;
    end else begin
      ack_q <= w_req;
      dat_q <= (w_req && !wbs.wbs_we_i) ? w_rdata : 32'h0;
    end
  end

  // Control/status bits: EN and the sticky underflow flag.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      en_q        <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (w_wr_ctrl && wbs.wbs_sel_i[0]) en_q <= wbs.wbs_dat_i[0];
      if (w_wr_seed || (w_wr_ctrl && wbs.wbs_sel_i[0] && wbs.wbs_dat_i[1]))
        underflow_q <= 1'b0;
      else if (w_rd_data && w_empty)
        underflow_q <= 1'b1;
    end
  end

  // Generator bank: only the round-robin-selected channel steps on a push.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < CHANNELS; i++) s_q[i] <= seed_mix(SEED, i);
      rr_q <= '0;
    end else if (w_wr_seed) begin
      for (int i = 0; i < CHANNELS; i++) s_q[i] <= seed_mix(w_seed_eff, i);
      rr_q <= '0;
    end else if (w_push) begin
      s_q[rr_q] <= w_next;
      rr_q      <= rr_d;
    end
  end

  // FIFO pointers and occupancy; a seed write empties the buffer.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (w_wr_seed) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (w_push) wptr_q <= wptr_q + 1'b1;
      if (w_pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // FIFO storage; contents are don't-care while the occupancy is zero.
  always_ff @(posedge wb_clk_i) begin
    if (w_push) mem_q[wptr_q] <= w_next;
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_rng_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_wb_rng_fifo                                               |
// | Description : Self-checking bench for wb_rng_fifo (default parameters).    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_wb_rng_fifo;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_rng_fifo_if bus_if ();

  wb_rng_fifo dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs      (bus_if)
  );

  typedef struct {
    logic        we;
    logic [3:0]  off;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl [16];
  logic [31:0] sb [$];
  logic [31:0] ms [2];
  int          nvec  = 0;
  int          nfail = 0;

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  // Reference generator: reseed and queue the expected output sequence.
  task automatic model_load(input logic [31:0] v);
    int rr;
    if (v == 32'h0) v = 32'h1;
    ms[0] = v;
    ms[1] = v ^ 32'h9E37_79B9;
    rr = 0;
    sb.delete();
    for (int k = 0; k < 64; k++) begin
      ms[rr] = xs(ms[rr]);
      sb.push_back(ms[rr]);
      rr = (rr + 1) % 2;
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, output logic [31:0] rd, output logic acked);
    @(negedge clk);
    bus_if.wbs_cyc_i = 1'b1;
    bus_if.wbs_stb_i = 1'b1;
    bus_if.wbs_we_i  = we;
    bus_if.wbs_adr_i = adr;
    bus_if.wbs_dat_i = dat;
    bus_if.wbs_sel_i = sel;
    acked = 1'b0;
    rd    = 32'h0;
    for (int k = 0; k < 4 && !acked; k++) begin
      @(posedge clk);
      #1;
      if (bus_if.wbs_ack_o) begin
        acked = 1'b1;
        rd    = bus_if.wbs_dat_o;
      end
    end
    @(negedge clk);
    bus_if.wbs_cyc_i = 1'b0;
    bus_if.wbs_stb_i = 1'b0;
    bus_if.wbs_we_i  = 1'b0;
  endtask

  task automatic acc(input string nm, input logic we, input logic [3:0] off,
                     input logic [31:0] dat, input logic [3:0] sel, input logic [31:0] exp);
    logic [31:0] rd;
    logic        ok;
    bus(we, BASE + {28'h0, off}, dat, sel, rd, ok);
    if (!ok) begin
      nvec++;
      nfail++;
      $display("FAIL %s: got no ack, expected ack", nm);
    end else begin
      check(nm, rd, exp);
    end
  endtask

  task automatic pop_chk(input string nm);
    logic [31:0] exp;
    if (sb.size() == 0) begin
      nvec++;
      nfail++;
      $display("FAIL %s: got empty scoreboard, expected queued value", nm);
    end else begin
      exp = sb.pop_front();
      acc(nm, 1'b0, 4'hC, 32'h0, 4'hF, exp);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        ok;
    logic [3:0]  pat;

    bus_if.wbs_cyc_i = 1'b0;
    bus_if.wbs_stb_i = 1'b0;
    bus_if.wbs_we_i  = 1'b0;
    bus_if.wbs_sel_i = 4'h0;
    bus_if.wbs_adr_i = 32'h0;
    bus_if.wbs_dat_i = 32'h0;

    tbl[0]  = '{1'b0, 4'h0, 32'h0,         4'hF, 32'h0};
    tbl[1]  = '{1'b1, 4'h0, 32'hFFFF_FFFE, 4'hF, 32'h0};
    tbl[2]  = '{1'b0, 4'h0, 32'h0,         4'hF, 32'h0};
    tbl[3]  = '{1'b1, 4'h0, 32'h0000_0001, 4'hE, 32'h0};
    tbl[4]  = '{1'b0, 4'h0, 32'h0,         4'hF, 32'h0};
    tbl[5]  = '{1'b0, 4'h8, 32'h0,         4'hF, 32'h0};
    tbl[6]  = '{1'b1, 4'h4, 32'hFFFF_FFFF, 4'hF, 32'h0};
    tbl[7]  = '{1'b0, 4'h4, 32'h0,         4'hF, 32'h0000_0001};
    tbl[8]  = '{1'b1, 4'hC, 32'hFFFF_FFFF, 4'hF, 32'h0};
    tbl[9]  = '{1'b0, 4'h4, 32'h0,         4'hF, 32'h0000_0001};
    tbl[10] = '{1'b0, 4'hC, 32'h0,         4'hF, 32'h0};
    tbl[11] = '{1'b0, 4'h4, 32'h0,         4'hF, 32'h0000_0005};
    tbl[12] = '{1'b1, 4'h0, 32'h0000_0002, 4'hE, 32'h0};
    tbl[13] = '{1'b0, 4'h4, 32'h0,         4'hF, 32'h0000_0005};
    tbl[14] = '{1'b1, 4'h0, 32'h0000_0002, 4'h1, 32'h0};
    tbl[15] = '{1'b0, 4'h4, 32'h0,         4'hF, 32'h0000_0001};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'b0, bus_if.wbs_ack_o}, 32'h0);
    check("rst_dat", bus_if.wbs_dat_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    acc("rst_status", 1'b0, 4'h4, 32'h0, 4'hF, 32'h0000_0001);

    // Register map, byte lanes, underflow set/clear (EN stays 0)
    for (int i = 0; i < 16; i++)
      acc($sformatf("tbl%0d", i), tbl[i].we, tbl[i].off, tbl[i].dat, tbl[i].sel, tbl[i].exp);

    // First generated word after enabling
    model_load(32'h1);
    acc("en_on", 1'b1, 4'h0, 32'h1, 4'hF, 32'h0);
    repeat (2) @(posedge clk);
    check("first_const", sb[0], 32'h0004_2021);
    pop_chk("first_data");

    // Fill to full, generators freeze, then continuous reads keep order
    repeat (20) @(posedge clk);
    acc("full_status", 1'b0, 4'h4, 32'h0, 4'hF, 32'h0000_0802);
    for (int i = 0; i < 20; i++) pop_chk($sformatf("stream%0d", i));
    acc("en_off", 1'b1, 4'h0, 32'h0, 4'hF, 32'h0);
    acc("full_status2", 1'b0, 4'h4, 32'h0, 4'hF, 32'h0000_0802);
    for (int i = 0; i < 8; i++) pop_chk($sformatf("drain%0d", i));
    acc("drained_status", 1'b0, 4'h4, 32'h0, 4'hF, 32'h0000_0001);

    // Underflow sticky, then cleared by a SEED write
    acc("uflow_read", 1'b0, 4'hC, 32'h0, 4'hF, 32'h0);
    acc("uflow_status", 1'b0, 4'h4, 32'h0, 4'hF, 32'h0000_0005);

    // SEED write while generating (byte lane 0 only) restarts the sequence
    acc("en_on2", 1'b1, 4'h0, 32'h1, 4'hF, 32'h0);
    acc("seed_lane", 1'b1, 4'h8, 32'h1234_5678, 4'h1, 32'h0);
    model_load(32'h0000_0078);
    repeat (12) @(posedge clk);
    acc("seed_full", 1'b0, 4'h4, 32'h0, 4'hF, 32'h0000_0802);
    for (int i = 0; i < 5; i++) pop_chk($sformatf("seeded%0d", i));

    // SEED=0 falls back to the parameter seed and flushes
    acc("en_off2", 1'b1, 4'h0, 32'h0, 4'hF, 32'h0);
    acc("seed_zero", 1'b1, 4'h8, 32'h0, 4'hF, 32'h0);
    model_load(32'h0);
    acc("flush_status", 1'b0, 4'h4, 32'h0, 4'hF, 32'h0000_0001);
    acc("en_on3", 1'b1, 4'h0, 32'h1, 4'hF, 32'h0);
    repeat (3) @(posedge clk);
    acc("en_off3", 1'b1, 4'h0, 32'h0, 4'hF, 32'h0);
    pop_chk("reseed0");
    pop_chk("reseed1");

    // Out-of-window address gets no ack
    bus(1'b1, BASE + 32'h10, 32'h1, 4'hF, rd, ok);
    check("no_ack_oow", {31'b0, ok}, 32'h0);

    // Held request: ack on alternate cycles, data zero without ack
    @(negedge clk);
    bus_if.wbs_cyc_i = 1'b1;
    bus_if.wbs_stb_i = 1'b1;
    bus_if.wbs_we_i  = 1'b0;
    bus_if.wbs_adr_i = BASE + 32'h4;
    pat = 4'h0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      pat[k] = bus_if.wbs_ack_o;
      if (!bus_if.wbs_ack_o) check($sformatf("idle_dat%0d", k), bus_if.wbs_dat_o, 32'h0);
    end
    check("b2b_ack_pattern", {28'h0, pat}, 32'h0000_0005);
    @(negedge clk);
    bus_if.wbs_cyc_i = 1'b0;
    bus_if.wbs_stb_i = 1'b0;

    // Reset during a pending DATA read
    @(negedge clk);
    bus_if.wbs_cyc_i = 1'b1;
    bus_if.wbs_stb_i = 1'b1;
    bus_if.wbs_adr_i = BASE + 32'hC;
    @(posedge clk);
    #1;
    check("pend_ack", {31'b0, bus_if.wbs_ack_o}, 32'h1);
    rst = 1'b1;
    #1;
    check("rst_async_ack", {31'b0, bus_if.wbs_ack_o}, 32'h0);
    check("rst_async_dat", bus_if.wbs_dat_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus_if.wbs_cyc_i = 1'b0;
    bus_if.wbs_stb_i = 1'b0;
    pat = 4'h0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      pat[k] = bus_if.wbs_ack_o;
    end
    check("no_ack_after_rst", {28'h0, pat}, 32'h0);
    acc("post_rst_status", 1'b0, 4'h4, 32'h0, 4'hF, 32'h0000_0001);
    acc("post_rst_ctrl", 1'b0, 4'h0, 32'h0, 4'hF, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
